imm_extend_unit: RTL and testbench

- Registered, parametrised immediate-extension stage for the MIPS datapath; successor of the fixed 16-to-32 sign extender.
- Accepts an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit operand: sign-extend, zero-extend, upper-load, or branch offset.
- Sits between decode and the ALU/branch unit.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer for full throughput under backpressure.

---
 rtl/imm_extend_unit.sv | 94 +++++++++
 tb/tb_imm_extend_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_unit.sv
// Registered immediate extender (sign/zero/upper/branch) with valid/ready and a 2-entry skid buffer.
// Optional build macro IMM_BRANCH_TARGET_EN adds in_pc and makes mode 11 produce a full branch target.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
`ifdef IMM_BRANCH_TARGET_EN
  input  logic [OUT_W-1:0] in_pc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  typedef enum logic [1:0] {
    MODE_SEXT   = 2'b00,
    MODE_ZEXT   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } immMode_e;

  logic             inXfer;
  logic             mainFree;
  logic             skidValid;
  logic             skidNext;
  logic [OUT_W-1:0] skidData;
  logic [1:0]       skidMode;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] branchOff;
  logic [OUT_W-1:0] conv;

  assign inXfer   = in_valid && in_ready;
  assign mainFree = !out_valid || out_ready;
  // A beat in the skid always moves to main when it frees, so skid can only stay or fill while main is stalled.
  assign skidNext = mainFree ? 1'b0 : (skidValid || inXfer);

  always_comb begin
    sext      = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    branchOff = {sext[OUT_W-3:0], 2'b00};
    conv      = '0;
    unique case (immMode_e'(in_mode))
      MODE_SEXT:   conv = sext;
      MODE_ZEXT:   conv = {{(OUT_W-IN_W){1'b0}}, in_imm};
      MODE_UPPER:  conv = {in_imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_BRANCH_TARGET_EN
      // The pc is folded into the converted value, so the skid carries it implicitly.
      MODE_BRANCH: conv = in_pc + OUT_W'(4) + branchOff;
`else
      MODE_BRANCH: conv = branchOff;
`endif
      default:     conv = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
      skidValid <= 1'b0;
      skidData  <= '0;
      skidMode  <= '0;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= !skidNext;
      if (mainFree) begin
        if (skidValid) begin
          out_valid <= 1'b1;
          out_data  <= skidData;
          out_mode  <= skidMode;
          skidValid <= 1'b0;
        end else begin
          out_valid <= inXfer;
          if (inXfer) begin
            out_data <= conv;
            out_mode <= in_mode;
          end
        end
      end else if (inXfer) begin
        skidValid <= 1'b1;
        skidData  <= conv;
        skidMode  <= in_mode;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Scoreboard bench for imm_extend_unit: driver queues expected beats on accept, monitor pops on output transfer.
module tb_imm_extend_unit;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [OUT_W-1:0] in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  always #5 clk = ~clk;

  imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_imm(in_imm),
    .in_mode(in_mode),
`ifdef IMM_BRANCH_TARGET_EN
    .in_pc(in_pc),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_mode(out_mode)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  beat_t       sbq[$];
  logic [31:0] expData;
  logic [1:0]  expMode;
  int          errors = 0;
  int          checks = 0;
  int          outCnt = 0;
  logic        holdPending = 1'b0;
  logic [31:0] heldData;
  logic [1:0]  heldMode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks output transfers and stall stability, then records accepted beats.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sbq.delete();
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, heldData);
        chk("stall_mode", {30'd0, out_mode}, {30'd0, heldMode});
      end
      if (out_valid && out_ready) begin
        outCnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_out", out_data, 32'hDEADBEEF ^ out_data ^ 32'h1);
        end else begin
          beat_t e;
          e = sbq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_mode", {30'd0, out_mode}, {30'd0, e.mode});
        end
      end
      holdPending = out_valid && !out_ready;
      heldData    = out_data;
      heldMode    = out_mode;
      if (in_valid && in_ready) sbq.push_back({expMode, expData});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp,
                      output int waits);
    waits    = 0;
    in_imm   = imm;
    in_mode  = mode;
    expData  = exp;
    expMode  = mode;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits >= 50) break;
    end
    if (waits >= 50) chk("accept_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    #1;
  endtask

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  initial begin
    int w;
    int totalWait;
    int base;
    vecs[0] = {16'd5323, 2'b00, 32'h000014CB};
    vecs[1] = {16'hFEBD, 2'b00, 32'hFFFFFEBD};
    vecs[2] = {16'hFEBD, 2'b01, 32'h0000FEBD};
    vecs[3] = {16'h1234, 2'b10, 32'h12340000};
    vecs[4] = {16'h8000, 2'b00, 32'hFFFF8000};
    vecs[5] = {16'h7FFF, 2'b00, 32'h00007FFF};
    vecs[6] = {16'hFFFF, 2'b10, 32'hFFFF0000};
`ifdef IMM_BRANCH_TARGET_EN
    vecs[7] = {16'hFFFF, 2'b11, 32'h00400000};
    vecs[8] = {16'h8000, 2'b11, 32'h003E0004};
    vecs[9] = {16'h0001, 2'b11, 32'h00400008};
`else
    vecs[7] = {16'hFFFF, 2'b11, 32'hFFFFFFFC};
    vecs[8] = {16'h8000, 2'b11, 32'hFFFE0000};
    vecs[9] = {16'h0001, 2'b11, 32'h00000004};
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_imm = '0; in_mode = '0; in_pc = 32'h00400000;
    expData = '0; expMode = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_mode", {30'd0, out_mode}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed conversions
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) send(vecs[i].imm, vecs[i].mode, vecs[i].exp, w);
    waitDrain();

    // Backpressure: A in main, B in skid, C stalled, then gapless drain
    tick();
    out_ready = 1'b0;
    send(16'd1, 2'b00, 32'd1, w);
    send(16'd2, 2'b00, 32'd2, w);
    fork
      send(16'd3, 2'b00, 32'd3, w);
      begin
        repeat (2) @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_main_A", out_data, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_gapless", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    waitDrain();

    // Streaming: one beat per cycle, in_ready never drops
    tick();
    out_ready = 1'b1;
    base = outCnt;
    totalWait = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'h0100 + 16'(i), 2'(i % 2), 32'h00000100 + 32'(i), w);
      totalWait += w;
    end
    waitDrain();
    chk("stream_waits", 32'(totalWait), 32'd0);
    chk("stream_count", 32'(outCnt - base), 32'd8);

    // Reset with main and skid both full
    tick();
    out_ready = 1'b0;
    send(16'h0011, 2'b01, 32'h00000011, w);
    send(16'h0022, 2'b01, 32'h00000022, w);
    @(negedge clk);
    chk("skid_full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    out_ready = 1'b1;
    base = outCnt;
    send(16'h0033, 2'b01, 32'h00000033, w);
    waitDrain();
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_single", 32'(outCnt - base), 32'd1);
    chk("queue_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
